// File: rtl/spiflash_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash responder.
// ST_DUMMY exists only when SPIFLASH_RESP_FASTREAD_EN is defined.
package spiflash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
`ifdef SPIFLASH_RESP_FASTREAD_EN
    , ST_DUMMY
`endif
  } state_t;

endpackage

// File: rtl/spiflash_responder_if.sv
// SPI pins plus backing-store read port of the flash responder.
interface spiflash_responder_if;
  logic        ncs;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_valid;

  modport slave  (input ncs, sck, mosi, mem_rdata, mem_valid,
                  output miso, mem_addr, mem_rd);
  modport master (output ncs, sck, mosi, mem_rdata, mem_valid,
                  input miso, mem_addr, mem_rd);
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus sck edge and ncs fall pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic resetn,
  input  logic ncs,
  input  logic sck,
  input  logic mosi,
  output logic ncs_sync,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall,
  output logic ncs_fall
);

  logic [1:0] ncs_ff;
  logic [1:0] sck_ff;
  logic [1:0] mosi_ff;
  logic [1:0] primed;
  logic       sck_prev;
  logic       ncs_prev;

  // primed marks when ncs_ff[1] holds a real pin sample, so the reset value
  // of the chain can never masquerade as a falling chip select
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ncs_ff   <= 2'b11;
      sck_ff   <= 2'b00;
      mosi_ff  <= 2'b00;
      primed   <= 2'b00;
      sck_prev <= 1'b0;
      ncs_prev <= 1'b0;
    end else begin
      ncs_ff   <= {ncs_ff[0], ncs};
      sck_ff   <= {sck_ff[0], sck};
      mosi_ff  <= {mosi_ff[0], mosi};
      primed   <= {primed[0], 1'b1};
      sck_prev <= sck_ff[1];
      ncs_prev <= ncs_ff[1] & primed[1];
    end
  end

  assign ncs_sync  = ncs_ff[1];
  assign mosi_sync = mosi_ff[1];
  assign sck_rise  = sck_ff[1] & ~sck_prev;
  assign sck_fall  = ~sck_ff[1] & sck_prev;
  assign ncs_fall  = ncs_prev & ~ncs_ff[1];

endmodule

// File: rtl/spiflash_responder.sv
// SPI mode-0 flash responder: READ, RDID, RDSR, other opcodes ignored.
// Define SPIFLASH_RESP_FASTREAD_EN to add FAST_READ (0Bh) with 8 dummy clocks.
module spiflash_responder
  import spiflash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID = 24'hEF4017,
  parameter int          MEM_LAT  = 2
) (
  input logic            clk,
  input logic            resetn,
  spiflash_responder_if.slave bus
);

  localparam int LAT_W = $clog2(MEM_LAT + 2);

  state_t      state, state_next;
  logic        ncs_sync, mosi_sync, sck_rise, sck_fall, ncs_fall;
  logic [22:0] shift_in;
  logic [4:0]  bit_cnt;
  logic [7:0]  shift_out;
  logic [7:0]  holding;
  logic [7:0]  next_byte;
  logic [1:0]  id_idx;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic        miso;
  logic        pending;
  logic [LAT_W-1:0] lat_cnt;
  logic        issue_rd;
  logic        shifting;
  logic [7:0]  opcode_now;
  logic [23:0] addr_now;
`ifdef SPIFLASH_RESP_FASTREAD_EN
  logic        fast;
`endif

  spi_pin_sync u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .ncs       (bus.ncs),
    .sck       (bus.sck),
    .mosi      (bus.mosi),
    .ncs_sync  (ncs_sync),
    .mosi_sync (mosi_sync),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .ncs_fall  (ncs_fall)
  );

  assign opcode_now = {shift_in[6:0], mosi_sync};
  assign addr_now   = {shift_in, mosi_sync};
  assign shifting   = (state == ST_DATA) || (state == ST_ID) || (state == ST_STAT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue_rd   = 1'b0;
    next_byte  = 8'h00;
    if (ncs_sync) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (ncs_fall) state_next = ST_CMD;
        ST_CMD: begin
          if (sck_rise && bit_cnt == 5'd7) begin
            case (opcode_now)
              OP_READ:      state_next = ST_ADDR;
              OP_RDID:      state_next = ST_ID;
              OP_RDSR:      state_next = ST_STAT;
`ifdef SPIFLASH_RESP_FASTREAD_EN
              OP_FAST_READ: state_next = ST_ADDR;
`else
              OP_FAST_READ: state_next = ST_IGNORE;
`endif
              default:      state_next = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (sck_rise && bit_cnt == 5'd23) begin
            issue_rd = 1'b1;
`ifdef SPIFLASH_RESP_FASTREAD_EN
            state_next = fast ? ST_DUMMY : ST_DATA;
`else
            state_next = ST_DATA;
`endif
          end
        end
`ifdef SPIFLASH_RESP_FASTREAD_EN
        ST_DUMMY: if (sck_rise && bit_cnt == 5'd7) state_next = ST_DATA;
`endif
        ST_DATA: if (sck_rise && bit_cnt[2:0] == 3'd0) issue_rd = 1'b1;
        default: ;
      endcase
    end
    case (state)
      ST_DATA: next_byte = holding;
      ST_ID: begin
        case (id_idx)
          2'd0:    next_byte = JEDEC_ID[23:16];
          2'd1:    next_byte = JEDEC_ID[15:8];
          2'd2:    next_byte = JEDEC_ID[7:0];
          default: next_byte = 8'h00;
        endcase
      end
      default: next_byte = 8'h00;
    endcase
  end

  // Reads older than MEM_LAT cycles, or cut off by ncs, are dropped unseen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_in  <= '0;
      bit_cnt   <= '0;
      shift_out <= '0;
      holding   <= '0;
      id_idx    <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      miso      <= 1'b0;
      pending   <= 1'b0;
      lat_cnt   <= '0;
`ifdef SPIFLASH_RESP_FASTREAD_EN
      fast      <= 1'b0;
`endif
    end else begin
      mem_rd <= issue_rd;
      if (issue_rd) begin
        pending  <= 1'b1;
        lat_cnt  <= '0;
        mem_addr <= (state == ST_ADDR) ? addr_now : mem_addr + 24'd1;
      end else if (pending) begin
        if (bus.mem_valid) begin
          holding <= bus.mem_rdata;
          pending <= 1'b0;
        end else if (lat_cnt == LAT_W'(MEM_LAT)) begin
          pending <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
      end

      if (ncs_sync) begin
        bit_cnt <= '0;
        id_idx  <= '0;
        miso    <= 1'b0;
        pending <= 1'b0;
      end else if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift_in <= addr_now[22:0];
        bit_cnt  <= (state_next != state) ? 5'd0 : bit_cnt + 5'd1;
`ifdef SPIFLASH_RESP_FASTREAD_EN
        if (state == ST_CMD) fast <= (opcode_now == OP_FAST_READ);
`endif
      end else if (sck_fall) begin
        if (shifting && bit_cnt[2:0] == 3'd0) begin
          shift_out <= next_byte;
          miso      <= next_byte[7];
          if (state == ST_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
        end else if (shifting) begin
          shift_out <= {shift_out[6:0], 1'b0};
          miso      <= shift_out[6];
        end else begin
          miso <= 1'b0;
        end
      end
    end
  end

  assign bus.miso     = miso;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_rd   = mem_rd;

endmodule

// File: tb/tb_spiflash_responder.sv
// Scoreboard bench for spiflash_responder: SPI master tasks queue expected
// miso bytes and read addresses; forked monitors pop and compare them.
module tb_spiflash_responder;
  import spiflash_pkg::*;

  localparam int HALF = 8;

  typedef struct {
    logic [7:0] val;
    bit         care;
  } exp_t;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  exp_t        byte_q[$];
  logic [23:0] addr_q[$];
  logic        rd_d1;
  logic [23:0] addr_d1;

  spiflash_responder_if bus();

  spiflash_responder #(.JEDEC_ID(24'hEF4017), .MEM_LAT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing store: data = addr[7:0] ^ A5h, two cycles after mem_rd
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_d1         <= 1'b0;
      addr_d1       <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      rd_d1         <= bus.mem_rd;
      addr_d1       <= bus.mem_addr;
      bus.mem_valid <= rd_d1;
      bus.mem_rdata <= addr_d1[7:0] ^ 8'hA5;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitHalf();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spiBits(input logic [7:0] tx, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      waitHalf();
      bus.sck = 1'b1;
      waitHalf();
      bus.sck = 1'b0;
    end
  endtask

  task automatic pushByte(input logic [7:0] v, input bit care);
    exp_t e;
    e.val  = v;
    e.care = care;
    byte_q.push_back(e);
  endtask

  // One full transaction: ntx command bytes out, then nrx checked reads
  task automatic applyStimulus(input logic [7:0] tx [6], input int ntx,
                               input logic [7:0] rx [4], input int nrx);
    for (int i = 0; i < ntx; i++) pushByte(8'h00, 1'b0);
    for (int i = 0; i < nrx; i++) pushByte(rx[i], 1'b1);
    bus.ncs = 1'b0;
    waitHalf();
    for (int i = 0; i < ntx; i++) spiBits(tx[i], 8);
    for (int i = 0; i < nrx; i++) spiBits(8'h00, 8);
    waitHalf();
    bus.ncs = 1'b1;
    repeat (2) waitHalf();
  endtask

  task automatic monitorBytes();
    logic [7:0] sh;
    int         cnt;
    exp_t       e;
    sh  = '0;
    cnt = 0;
    forever begin
      @(posedge bus.sck or posedge bus.ncs);
      if (bus.ncs) begin
        cnt = 0;
      end else begin
        sh = {sh[6:0], bus.miso};
        cnt++;
        if (cnt == 8) begin
          cnt = 0;
          if (byte_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL miso byte: got %h, expected no byte", sh);
          end else begin
            e = byte_q.pop_front();
            if (e.care) checkOutput("miso byte", {24'h0, sh}, {24'h0, e.val});
          end
        end
      end
    end
  endtask

  task automatic monitorReads();
    forever begin
      @(negedge clk);
      if (bus.mem_rd) begin
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL mem_rd addr: got %h, expected no read", bus.mem_addr);
        end else begin
          checkOutput("mem_rd addr", {8'h0, bus.mem_addr}, {8'h0, addr_q.pop_front()});
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected test end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total    = 0;
    bad      = 0;
    resetn   = 1'b0;
    bus.ncs  = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    fork
      monitorBytes();
      monitorReads();
    join_none
    repeat (4) @(negedge clk);
    checkOutput("reset miso", {31'h0, bus.miso}, 32'h0);
    checkOutput("reset mem_rd", {31'h0, bus.mem_rd}, 32'h0);
    checkOutput("reset mem_addr", {8'h0, bus.mem_addr}, 32'h0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] READ 100000h x4");
    for (int a = 0; a < 5; a++) addr_q.push_back(24'h100000 + 24'(a));
    applyStimulus('{8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                  '{8'hA5, 8'hA4, 8'hA7, 8'hA6}, 4);

    $display("[TB] RDID x4");
    applyStimulus('{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1,
                  '{8'hEF, 8'h40, 8'h17, 8'h00}, 4);

    $display("[TB] RDSR and unknown opcode");
    applyStimulus('{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1,
                  '{8'h00, 8'h00, 8'h00, 8'h00}, 2);
    applyStimulus('{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1,
                  '{8'h00, 8'h00, 8'h00, 8'h00}, 2);

    $display("[TB] READ across address wrap");
    addr_q.push_back(24'hFFFFFE);
    addr_q.push_back(24'hFFFFFF);
    addr_q.push_back(24'h000000);
    addr_q.push_back(24'h000001);
    applyStimulus('{8'h03, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00}, 4,
                  '{8'h5B, 8'h5A, 8'hA5, 8'h00}, 3);

    $display("[TB] aborted address then READ 000010h");
    pushByte(8'h00, 1'b0);
    pushByte(8'h00, 1'b0);
    bus.ncs = 1'b0;
    waitHalf();
    spiBits(8'h03, 8);
    spiBits(8'hAB, 8);
    spiBits(8'hC0, 4);
    waitHalf();
    bus.ncs = 1'b1;
    repeat (2) waitHalf();
    addr_q.push_back(24'h000010);
    addr_q.push_back(24'h000011);
    applyStimulus('{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00}, 4,
                  '{8'hB5, 8'h00, 8'h00, 8'h00}, 1);

    $display("[TB] FAST_READ 000020h");
`ifdef SPIFLASH_RESP_FASTREAD_EN
    addr_q.push_back(24'h000020);
    addr_q.push_back(24'h000021);
    applyStimulus('{8'h0B, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00}, 5,
                  '{8'h85, 8'h00, 8'h00, 8'h00}, 1);
`else
    applyStimulus('{8'h0B, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00}, 5,
                  '{8'h00, 8'h00, 8'h00, 8'h00}, 1);
`endif

    $display("[TB] reset released with ncs low");
    resetn  = 1'b0;
    bus.ncs = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    pushByte(8'h00, 1'b0);
    pushByte(8'h00, 1'b1);
    spiBits(8'h9F, 8);
    spiBits(8'h00, 8);
    waitHalf();
    bus.ncs = 1'b1;
    repeat (2) waitHalf();

    repeat (20) @(negedge clk);
    checkOutput("pending miso bytes", byte_q.size(), 32'd0);
    checkOutput("pending reads", addr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spiflash_responder.md
SPIFLASH_RESPONDER -- requirements
Module: spiflash_responder

Interface
REQ-001 SHALL have parameter JEDEC_ID, default 24'hEF4017, the 3 bytes returned for opcode 9Fh, MSB first.
REQ-002 SHALL have parameter MEM_LAT, default 2, the maximum clk cycles from mem_rd to mem_valid.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 ncs  input  1  SPI chip select from the initiator, active low, asynchronous to clk.
REQ-006 sck  input  1  SPI clock (mode 0), asynchronous to clk.
REQ-007 mosi  input  1  initiator-to-responder serial data.
REQ-008 miso  output  1  responder-to-initiator serial data, MSB first.
REQ-009 mem_addr  output  24  byte address of the next backing-store read.
REQ-010 mem_rd  output  1  one-cycle read request strobe.
REQ-011 mem_rdata  input  8  backing-store read data.
REQ-012 mem_valid  input  1  mem_rdata is valid this cycle.

Function
REQ-013 SHALL pass ncs, sck and mosi through 2-flop synchronizers, and SHALL detect sck rise/fall edges on the synchronized signal.
REQ-014 Operation SHALL be guaranteed only for an sck half-period of at least MEM_LAT+4 clk cycles.
REQ-015 SHALL sample mosi on the sck rise edge and SHALL update miso on the sck fall edge.
REQ-016 States: IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE (DUMMY only with REQ-028).
REQ-017 IDLE->CMD SHALL occur on the synchronized ncs fall edge; the bit counter SHALL clear at this point.
REQ-018 Synchronized ncs high in any state SHALL return the block to IDLE within one cycle and SHALL abandon any partial byte or pending read without error.
REQ-019 After 8 bits in CMD, the opcode SHALL select the next state: 03h->ADDR, 9Fh->ID, 05h->STAT, any other value->IGNORE.
REQ-020 ADDR SHALL shift in 24 address bits MSB first; on the 24th rise edge it SHALL set mem_addr to the address, pulse mem_rd, and enter DATA.
REQ-021 In DATA, mem_rdata SHALL be captured into a holding byte on mem_valid.
REQ-022 In DATA, the holding byte SHALL load into the output shift register at each byte boundary, and bit 7 SHALL drive miso on the following sck fall edge.
REQ-023 In DATA, on the first rise edge of each byte, mem_addr SHALL increment and mem_rd SHALL pulse to prefetch the next byte.
REQ-024 mem_addr SHALL wrap from FFFFFFh to 000000h.
REQ-025 ID SHALL return JEDEC_ID[23:16], [15:8], [7:0], and SHALL output 00h after the third byte.
REQ-026 STAT SHALL return 00h (never busy) repeatedly until ncs goes high.
REQ-027 IGNORE SHALL drive miso 0 and ignore sck until ncs goes high.

Configuration
REQ-028 With SPIFLASH_RESP_FASTREAD_EN defined, opcode 0Bh SHALL be accepted as ADDR followed by a DUMMY state of 8 sck cycles, then DATA exactly as for 03h.
REQ-029 Without SPIFLASH_RESP_FASTREAD_EN, 0Bh SHALL go to IGNORE, and the DUMMY state SHALL be absent from the RTL.

Reset
REQ-030 On resetn low: state SHALL be IDLE, miso SHALL be 0, mem_rd SHALL be 0, mem_addr SHALL be 000000h, all shift registers and counters SHALL be 0, and synchronizer flops SHALL be ncs=1, sck=0, mosi=0.
REQ-031 Reset deasserted mid-transaction (ncs low) SHALL leave the block in IDLE until the next ncs fall edge.

Structure
REQ-032 Package spiflash_pkg SHALL hold the opcode constants (OP_READ=03h, OP_FAST_READ=0Bh, OP_RDID=9Fh, OP_RDSR=05h) and the state enumeration.
REQ-033 Sub-module spi_pin_sync SHALL contain the three 2-flop synchronizers and the sck rise/fall edge pulses.

Verification
REQ-034 03h, address 100000h, read 4 bytes, memory returning addr[7:0]^A5h -> miso returns A5h A4h A7h A6h, and mem_rd pulses at addresses 100000h..100004h.
REQ-035 9Fh then 4 bytes read -> miso returns EFh 40h 17h 00h.
REQ-036 05h then 2 bytes -> miso returns 00h 00h; opcode 5Ah then 2 bytes -> miso returns 00h 00h, and mem_rd never pulses.
REQ-037 03h, address FFFFFEh, read 3 bytes -> mem_addr sequence FFFFFEh, FFFFFFh, 000000h.
REQ-038 ncs raised after 12 address bits, then 03h 000010h -> the first data byte comes from 000010h, and no stale read occurs.
REQ-039 With the macro defined: 0Bh 000020h, 8 dummy clocks, 1 byte -> the data comes from 000020h; without the macro, the same stimulus -> 00h and no mem_rd.
